// File: rtl/serializer_pkg.sv
// serializer_pkg: shared widths, derivation functions and the word record for serializer_bp
package serializer_pkg;
  function automatic int in_width(input int word_width, input int data_width);
    return word_width + data_width - 1;
  endfunction
  function automatic int cnt_w(input int max_values);
    return $clog2(max_values + 1);
  endfunction
  localparam int DEF_WORD_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 7;
  localparam int DEF_IN_WIDTH = in_width(DEF_WORD_WIDTH, DEF_DATA_WIDTH);
  localparam int DEF_MAX_VALUES = DEF_IN_WIDTH / DEF_DATA_WIDTH;
  localparam int DEF_CNT_W = cnt_w(DEF_MAX_VALUES);
  typedef struct packed {
    logic first;
    logic last;
    logic [DEF_CNT_W-1:0] num_values;
    logic [DEF_IN_WIDTH-1:0] word;
  } word_rec_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: word FIFO; wr/wdata/full on the write side, rd/rdata/empty on the read side, async active-low reset
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  // extra pointer bit distinguishes full from empty when the indices match
  assign full = (wp ^ rp) == {1'b1, {AW{1'b0}}};
  assign empty = wp == rp;
  assign rdata = mem[rp[AW-1:0]];
  always_ff @(posedge clk)
    if (wr && !full) mem[wp[AW-1:0]] <= wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr && !full) wp <= wp + 1'b1;
      if (rd && !empty) rp <= rp + 1'b1;
    end
endmodule

// File: rtl/serializer_bp.sv
// serializer_bp: packed-word to value serializer with ready/valid on both sides
// in_*: word handshake with first/last flags and value count; out_*: one value per handshake
// value_index: position in emit order; num_err: pulse for an over-long count; busy: work pending
module serializer_bp
  import serializer_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_VALUES = in_width(WORD_WIDTH, DATA_WIDTH) / DATA_WIDTH,
  parameter int FIFO_DEPTH = 2,
  parameter int MSB_FIRST = 0,
  localparam int CNT_W = cnt_w(MAX_VALUES),
  localparam int IN_WIDTH = in_width(WORD_WIDTH, DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_first,
  input  logic                  in_last,
  input  logic [CNT_W-1:0]      in_num_values,
  input  logic [IN_WIDTH-1:0]   in_word,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_first,
  output logic                  out_last,
  output logic [CNT_W-1:0]      value_index,
  output logic                  num_err,
  output logic                  busy
);
  localparam int MW = MAX_VALUES * DATA_WIDTH;
  // bits of in_word above MW can never hold a whole value, so they are not stored
  typedef struct packed {
    logic first;
    logic last;
    logic [CNT_W-1:0] num_values;
    logic [MW-1:0] word;
  } rec_t;
  rec_t wr_rec, rd_rec;
  logic full, empty, acc, over, wr, rd, fire;
  logic [MW-1:0] sh, ld_sh;
  logic [CNT_W-1:0] rem, idx;
  logic ff, lf;
  assign in_ready = rst_n && !full;
  assign acc = in_valid && in_ready;
  assign over = in_num_values > CNT_W'(MAX_VALUES);
  assign wr = acc && in_num_values != '0;
  assign wr_rec = '{first: in_first, last: in_last,
                    num_values: over ? CNT_W'(MAX_VALUES) : in_num_values,
                    word: in_word[MW-1:0]};
  assign out_valid = rem != '0;
  assign fire = out_valid && out_ready;
  // reload when idle or as the final value leaves, so words run back to back
  assign rd = !empty && (!out_valid || (fire && rem == CNT_W'(1)));
  // MSB-first left-aligns the used slots so the top slot is always the next value
  assign ld_sh = MSB_FIRST != 0 ? rd_rec.word << (DATA_WIDTH * (MAX_VALUES - int'(rd_rec.num_values))) : rd_rec.word;
  assign out_data = !out_valid ? '0 : MSB_FIRST != 0 ? sh[MW-1 -: DATA_WIDTH] : sh[DATA_WIDTH-1:0];
  assign out_first = out_valid && ff && idx == '0;
  assign out_last = out_valid && lf && rem == CNT_W'(1);
  assign value_index = idx;
  assign busy = out_valid || !empty;
  sync_fifo #(.WIDTH($bits(rec_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .wr(wr), .wdata(wr_rec), .full(full),
    .rd(rd), .rdata(rd_rec), .empty(empty)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sh <= '0;
      rem <= '0;
      idx <= '0;
      ff <= 1'b0;
      lf <= 1'b0;
      num_err <= 1'b0;
    end else begin
      num_err <= acc && over;
      if (rd) begin
        sh <= ld_sh;
        rem <= rd_rec.num_values;
        idx <= '0;
        ff <= rd_rec.first;
        lf <= rd_rec.last;
      end else if (fire) begin
        sh <= MSB_FIRST != 0 ? sh << DATA_WIDTH : sh >> DATA_WIDTH;
        rem <= rem - CNT_W'(1);
        idx <= rem == CNT_W'(1) ? '0 : idx + CNT_W'(1);
      end
    end
endmodule
